multicycle_alu: RTL and testbench

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_mul_seq.sv | 58 +++++
 rtl/multicycle_alu.sv | 132 +++++++++++++
 tb/tb_multicycle_alu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM encoding and width default for multicycle_alu
package alu_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier, one multiplier bit per cycle, LSB first
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;

    // Bit 0 is consumed on the start edge, so the counter holds the index
    // of the multiplier bit being added this cycle; bit WIDTH-1 is the last.
    assign busy    = busy_q;
    assign last    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Accumulate one partial product per cycle while busy
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(1);
            acc_q    <= multiplier[0] ? multiplicand : '0;
            mcand_q  <= multiplicand << 1;
            mplier_q <= multiplier >> 1;
        end else if (busy_q) begin
            acc_q    <= product;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (last) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - ALU with single-cycle ops and a sequential multiply
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       aluctrl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             ovf_o,
    output logic             done_o
);

    localparam int SH_W = $clog2(WIDTH);

    alu_state_t       state_q;
    alu_state_t       state_d;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_last;
    logic [WIDTH-1:0] mul_product;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             ovf_q;
    logic             done_q;

    assign accept    = valid_i && ready_o;
    assign mul_start = accept && (aluctrl_i == OP_MUL);

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign ovf_o    = ovf_q;
    assign done_o   = done_q;

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start        (mul_start),
        .multiplicand (data1_i),
        .multiplier   (data2_i),
        .busy         (mul_busy),
        .last         (mul_last),
        .product      (mul_product)
    );

    // Single-cycle operations and add/sub signed overflow
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluctrl_i)
            OP_ADD: begin
                alu_res = data1_i + data2_i;
                alu_ovf = (data1_i[WIDTH-1] == data2_i[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = data1_i - data2_i;
                alu_ovf = (data1_i[WIDTH-1] != data2_i[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != data1_i[WIDTH-1]);
            end
            OP_AND:  alu_res = data1_i & data2_i;
            OP_OR:   alu_res = data1_i | data2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1_i) < $signed(data2_i))};
            OP_SLL:  alu_res = data1_i << data2_i[SH_W-1:0];
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake; requests are only taken in IDLE
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready_o = 1'b1;
                if (mul_start) begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mul_last || !mul_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result and flag registers; they hold between done pulses
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            result_q <= '0;
            zero_q   <= 1'b1;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept && (aluctrl_i != OP_MUL)) begin
                result_q <= alu_res;
                zero_q   <= (alu_res == '0);
                ovf_q    <= alu_ovf;
                done_q   <= 1'b1;
            end else if (mul_last) begin
                result_q <= mul_product;
                zero_q   <= (mul_product == '0);
                ovf_q    <= 1'b0;
                done_q   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - self-checking bench for multicycle_alu
module tb_multicycle_alu;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] r;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [W-1:0] data1_i = '0;
    logic [W-1:0] data2_i = '0;
    logic [2:0]   aluctrl_i = 3'b000;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         ovf_o;
    logic         done_o;

    int   checks = 0;
    int   errors = 0;
    int   done_seen = 0;
    exp_t exp_q[$];

    multicycle_alu #(.WIDTH(W)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data1_i   (data1_i),
        .data2_i   (data2_i),
        .aluctrl_i (aluctrl_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .ovf_o     (ovf_o),
        .done_o    (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (done_o) done_seen <= done_seen + 1;

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.o = 1'b0;
        case (op)
            3'd1: begin
                e.r = a + b;
                e.o = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd2: begin
                e.r = a - b;
                e.o = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
            end
            3'd3: e.r = a & b;
            3'd4: e.r = a | b;
            3'd5: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                e.r = p[W-1:0];
            end
            3'd6: e.r = ($signed(a) < $signed(b)) ? 1 : 0;
            3'd7: e.r = a << b[4:0];
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        return e;
    endfunction

    // Called just after a negedge: present a request for one edge and record the expectation
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        aluctrl_i = op;
        data1_i   = a;
        data2_i   = b;
        valid_i   = 1'b1;
        exp_q.push_back(model(op, a, b));
        @(negedge clk_i);
        valid_i = 1'b0;
    endtask

    // Waits (bounded) at negedges for done_o; reports how many cycles it waited
    task automatic wait_done(input int budget, output logic ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (waited < budget) begin
            if (done_o) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk_i);
            waited++;
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        checks++; if (result_o !== '0)  begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        checks++; if (zero_o !== 1'b1)  begin errors++; $display("FAIL reset_zero got %b want 1", zero_o); end
        checks++; if (ovf_o !== 1'b0)   begin errors++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
        checks++; if (done_o !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready_o); end
    endtask

    // Single-cycle ops: done must appear at the first negedge after the accept edge
    task automatic test_single(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        int   waited;
        exp_t e;
        send(op, a, b);
        wait_done(4, ok, waited);
        checks++;
        if (!ok || waited != 0) begin
            errors++;
            $display("FAIL %s_latency got done=%b after %0d cycles want done after 0", name, ok, waited);
        end
        e = exp_q.pop_front();
        checks++; if (result_o !== e.r) begin errors++; $display("FAIL %s_result got %h want %h", name, result_o, e.r); end
        checks++; if (zero_o !== e.z)   begin errors++; $display("FAIL %s_zero got %b want %b", name, zero_o, e.z); end
        checks++; if (ovf_o !== e.o)    begin errors++; $display("FAIL %s_ovf got %b want %b", name, ovf_o, e.o); end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready got %b want 1", name, ready_o); end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        aluctrl_i = 3'd2; data1_i = 5; data2_i = 5; valid_i = 1'b1;
        exp_q.push_back(model(3'd2, 5, 5));
        @(negedge clk_i);
        e = exp_q.pop_front();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", done_o); end
        checks++; if (result_o !== e.r || zero_o !== e.z || ovf_o !== e.o) begin
            errors++; $display("FAIL b2b_res1 got %h/%b/%b want %h/%b/%b", result_o, zero_o, ovf_o, e.r, e.z, e.o);
        end
        aluctrl_i = 3'd3; data1_i = 32'hF0; data2_i = 32'h3C;
        exp_q.push_back(model(3'd3, 32'hF0, 32'h3C));
        @(negedge clk_i);
        valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b want 1", done_o); end
        checks++; if (result_o !== 32'h30 || result_o !== e.r) begin
            errors++; $display("FAIL b2b_res2 got %h want %h", result_o, e.r);
        end
        @(negedge clk_i);
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_done_drop got %b want 0", done_o); end
        checks++; if (result_o !== e.r) begin errors++; $display("FAIL b2b_hold got %h want %h", result_o, e.r); end
    endtask

    // Mul with interfering requests during the busy window
    task automatic test_mul(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        int   start_done;
        int   bad_ready;
        int   bad_done;
        exp_t e;
        bad_ready = 0;
        bad_done = 0;
        start_done = done_seen;
        send(3'd5, a, b);
        for (int i = 1; i <= 31; i++) begin
            if (ready_o !== 1'b0) bad_ready++;
            if (done_o !== 1'b0) bad_done++;
            aluctrl_i = 3'd1;
            data1_i = $urandom;
            data2_i = $urandom;
            valid_i = 1'b1;
            @(negedge clk_i);
        end
        valid_i = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bad_ready != 0) begin errors++; $display("FAIL %s_busy_ready got %0d ready cycles want 0", name, bad_ready); end
        checks++; if (bad_done != 0)  begin errors++; $display("FAIL %s_early_done got %0d done cycles want 0", name, bad_done); end
        checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL %s_done_t32 got %b want 1", name, done_o); end
        checks++; if (result_o !== e.r) begin errors++; $display("FAIL %s_result got %h want %h", name, result_o, e.r); end
        checks++; if (zero_o !== e.z || ovf_o !== 1'b0) begin
            errors++; $display("FAIL %s_flags got z=%b o=%b want z=%b o=0", name, zero_o, ovf_o, e.z);
        end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b want 1", name, ready_o); end
        @(negedge clk_i);
        checks++; if (done_seen - start_done != 1) begin
            errors++; $display("FAIL %s_done_count got %0d want 1", name, done_seen - start_done);
        end
    endtask

    task automatic test_reset_mid_mul;
        int   start_done;
        start_done = done_seen;
        send(3'd5, 32'h12345, 32'h100);
        repeat (9) @(negedge clk_i);
        rst_i = 1'b0;
        valid_i = 1'b1;
        aluctrl_i = 3'd1; data1_i = 1; data2_i = 1;
        @(negedge clk_i);
        rst_i = 1'b1;
        valid_i = 1'b0;
        exp_q.delete();
        checks++; if (result_o !== '0 || zero_o !== 1'b1 || ovf_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL rstmul_outputs got %h/%b/%b/%b want 0/1/0/0", result_o, zero_o, ovf_o, done_o);
        end
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rstmul_ready got %b want 1", ready_o); end
        repeat (40) @(negedge clk_i);
        checks++; if (done_seen != start_done) begin
            errors++; $display("FAIL rstmul_no_done got %0d pulses want 0", done_seen - start_done);
        end
        test_single("rstmul_add", 3'd1, 32'd3, 32'd4);
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_single("add_ovf", 3'd1, 32'h7FFF_FFFF, 32'h1);
        test_back_to_back();
        test_single("sub_ovf", 3'd2, 32'h8000_0000, 32'h1);
        test_single("or", 3'd4, 32'hA5A5_0000, 32'h0000_5A5A);
        test_single("slt", 3'd6, 32'hFFFF_FFFF, 32'h1);
        test_single("slt_ge", 3'd6, 32'h1, 32'hFFFF_FFFF);
        test_single("sll", 3'd7, 32'h1, 32'd31);
        test_single("op0", 3'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        test_mul("mul", 32'h12345, 32'h100);
        test_mul("mul_rand", $urandom, $urandom);
        test_mul("mul_zero", 32'hDEAD_BEEF, 32'h0);
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
